clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Time-keeping and time-setting controller for the 4-digit HH:MM clock running on the 32768 Hz `clk`.
- Owns the BCD time registers and advances them on minute ticks from the external timebase.
- Sequences a button-driven set mode (hours, then minutes) with debounce, auto-repeat and digit blink.
- Drives BCD digits plus a per-digit blank mask to the bcd2seg/multiplex display path.

Parameters:
DEB_CYCLES, 512, consecutive stable synchronized samples required to accept a button level change (~15.6 ms)
REPEAT_DELAY, 16384, cycles btn_inc must stay held after its press event before the first auto-repeat
REPEAT_RATE, 4096, cycles between subsequent auto-repeat events while held
BLINK_HALF, 8192, cycles per blink half-period (visible half, then blanked half)

Ports:
clk  input  1  system clock, 32768 Hz
res  input  1  synchronous reset, active-high
btn_mode  input  1  raw asynchronous mode button, active-high
btn_inc  input  1  raw asynchronous increment button, active-high
tick_min  input  1  one-cycle minute tick from the timebase
hh  output  4  tens of hours, BCD 0..2
h  output  4  units of hours, BCD 0..9
mm  output  4  tens of minutes, BCD 0..5
m  output  4  units of minutes, BCD 0..9
blank  output  4  {hh,h,mm,m} blank mask; 1 = digit off
mode  output  2  0 = RUN, 1 = SET_HH, 2 = SET_MM
tb_clr  output  1  one-cycle pulse that clears the timebase prescaler

Behaviour:
- Single clock domain, `clk`. Reset is synchronous and active-high on `res`; all state is updated on the posedge of `clk`.
- Reset values:
  - time = 00:00
  - mode = RUN
  - blank = 0000
  - tb_clr = 0
  - debounced levels = 0; debounce, repeat and blink counters = 0
- A button held through reset produces a press event DEB_CYCLES+2 cycles after reset is released.
- Input conditioning, per button:
  - 2-flop synchronizer, then debounce counter.
  - The counter increments while the synchronized sample differs from the debounced level; it clears when they are equal.
  - When the count reaches DEB_CYCLES, the debounced level flips.
  - Net latency: raw change settled at cycle T → debounced flip at T+DEB_CYCLES+2.
  - Press event = one-cycle pulse in the cycle the debounced level rises. Releases generate no event.
- Auto-repeat, btn_inc only:
  - While debounced btn_inc is high, a hold counter runs from its press event.
  - An inc event is generated at the press, at REPEAT_DELAY after the press, then every REPEAT_RATE cycles.
  - Release clears the hold counter.
- State machine:
  - RUN --mode press--> SET_HH
  - SET_HH --mode press--> SET_MM
  - SET_MM --mode press--> RUN; tb_clr pulses in the same cycle as the transition.
- RUN:
  - tick_min increments m, with carry into mm (9→0), h (5→0), hh.
  - 23:59 → 00:00; 09:59 → 10:00; 19:59 → 20:00.
  - inc events are ignored.
- SET_HH:
  - inc event increments hours only, 00..23, wrapping 23 → 00. Minutes are unchanged.
  - tick_min is ignored (dropped, not queued).
- SET_MM:
  - inc event increments minutes only, 00..59, wrapping 59 → 00. There is no carry into hours.
  - tick_min is ignored.
- Simultaneous events:
  - Mode press and inc event in the same cycle: the mode transition wins and the inc is discarded.
  - tick_min and mode press in RUN in the same cycle: the tick is applied and the state moves to SET_HH.
- Blink:
  - The blink counter wraps at 2*BLINK_HALF. Phase is visible for counts 0..BLINK_HALF-1 and blanked for the rest.
  - The counter clears to 0 on every state transition and every applied inc event, so a changed value is shown immediately.
- Blank mask:
  - RUN: blank = 0000.
  - SET_HH: blank = 1100 in the blanked phase, else 0000.
  - SET_MM: blank = 0011 in the blanked phase, else 0000.
  - Hour leading-zero suppression is done downstream, not here.
- All outputs are registered. Time, mode and blank update one cycle after the causing event.
- Reset asserted mid-set: time returns to 00:00, mode to RUN, no tb_clr pulse.
- Time digits never take illegal BCD values. No illegal state is reachable; encoding 3 recovers to RUN.

Test Plan:
Bench parameters for all scenarios: DEB_CYCLES=4, REPEAT_DELAY=32, REPEAT_RATE=8, BLINK_HALF=16.
1. Reset, then 1439 tick_min pulses → time 23:59; one more pulse → 00:00. Check the 09:59→10:00 and 19:59→20:00 rollovers en route.
2. btn_mode raw high with 2-cycle glitches (shorter than DEB_CYCLES) → no mode change. Clean press → mode=1 exactly 6 cycles after the settle edge, plus 1 cycle for the registered output.
3. In SET_HH from 22:xx, two inc presses → hours 23, then 00. Minutes unchanged. tick_min pulses during SET_HH → no time change.
4. SET_MM, hold btn_inc for 60 cycles after its press event → inc events at +0, +32, +40, +48, +56: m advances by 5. Starting at 58 → 03, hours unchanged.
5. SET_MM → mode press → mode=0 and a single-cycle tb_clr. In the same cycle as an inc event → the inc is discarded.
6. In SET_HH, observe blank toggling 0000/1100 every 16 cycles. An inc press mid-blank → blank=0000 on the next cycle. Assert res mid-SET_MM → 00:00, mode=0, blank=0000.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - HH:MM time-keeping and button-driven time-set controller
module clock_set_ctrl #(
  parameter int DEB_CYCLES   = 512,
  parameter int REPEAT_DELAY = 16384,
  parameter int REPEAT_RATE  = 4096,
  parameter int BLINK_HALF   = 8192
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_min,
  output logic [3:0] hh,
  output logic [3:0] h,
  output logic [3:0] mm,
  output logic [3:0] m,
  output logic [3:0] blank,
  output logic [1:0] mode,
  output logic       tb_clr
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SET_HH = 2'd1,
    S_SET_MM = 2'd2,
    S_BAD    = 2'd3
  } state_t;

  // Counter widths: debounce counts 0..DEB-1, hold counts 0..DELAY+RATE-1,
  // blink counts 0..2*HALF-1.
  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HOLD_W  = $clog2(REPEAT_DELAY + REPEAT_RATE);
  localparam int BLINK_W = $clog2(2 * BLINK_HALF);

  // Bit 0 = mode button, bit 1 = inc button.
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_deb;
  logic [1:0]         r_deb_d;
  logic [DEB_W-1:0]   r_deb_cnt [2];
  logic [HOLD_W-1:0]  r_hold;
  logic [BLINK_W-1:0] r_blink;
  state_t             r_state;
  logic [3:0]         r_hh;
  logic [3:0]         r_h;
  logic [3:0]         r_mm;
  logic [3:0]         r_m;
  logic [3:0]         r_blank;
  logic               r_tb_clr;

  logic [1:0]         w_press;
  logic               w_mode_evt;
  logic               w_inc_evt;
  logic [3:0]         w_hh_nxt;
  logic [3:0]         w_h_nxt;
  logic [3:0]         w_mm_nxt;
  logic [3:0]         w_m_nxt;
  logic               w_min_wrap;
  logic [BLINK_W-1:0] w_blink_inc;
  logic               w_blink_off;

  // Synchronize both buttons and flip each debounced level after DEB_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (res) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_deb   <= 2'b00;
      r_deb_d <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= {btn_inc, btn_mode};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press    = r_deb & ~r_deb_d;
  assign w_mode_evt = w_press[0];

  // Hold timer for inc auto-repeat; after the first repeat it cycles in the
  // REPEAT_DELAY..REPEAT_DELAY+REPEAT_RATE-1 window so repeats stay periodic.
  always_ff @(posedge clk) begin
    if (res || !r_deb[1]) begin
      r_hold <= '0;
    end else if (r_hold == HOLD_W'(REPEAT_DELAY + REPEAT_RATE - 1)) begin
      r_hold <= HOLD_W'(REPEAT_DELAY);
    end else begin
      r_hold <= r_hold + 1'b1;
    end
  end

  assign w_inc_evt = w_press[1] | (r_deb[1] & (r_hold == HOLD_W'(REPEAT_DELAY)));

  // BCD successor values for the hour pair (00..23) and minute pair (00..59).
  always_comb begin
    w_hh_nxt   = r_hh;
    w_h_nxt    = r_h + 4'd1;
    w_mm_nxt   = r_mm;
    w_m_nxt    = r_m + 4'd1;
    w_min_wrap = 1'b0;
    if (r_hh == 4'd2 && r_h == 4'd3) begin
      w_hh_nxt = 4'd0;
      w_h_nxt  = 4'd0;
    end else if (r_h == 4'd9) begin
      w_hh_nxt = r_hh + 4'd1;
      w_h_nxt  = 4'd0;
    end
    if (r_m == 4'd9) begin
      w_m_nxt = 4'd0;
      if (r_mm == 4'd5) begin
        w_mm_nxt   = 4'd0;
        w_min_wrap = 1'b1;
      end else begin
        w_mm_nxt = r_mm + 4'd1;
      end
    end
  end

  assign w_blink_inc = (r_blink == BLINK_W'(2 * BLINK_HALF - 1)) ? '0 : r_blink + 1'b1;
  assign w_blink_off = (w_blink_inc >= BLINK_W'(BLINK_HALF));

  // Mode sequencer, time registers, blink phase and registered outputs.
  // A mode press always takes priority over a coincident inc event.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= S_RUN;
      r_hh     <= 4'd0;
      r_h      <= 4'd0;
      r_mm     <= 4'd0;
      r_m      <= 4'd0;
      r_blink  <= '0;
      r_blank  <= 4'b0000;
      r_tb_clr <= 1'b0;
    end else begin
      r_tb_clr <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (tick_min) begin
            r_m  <= w_m_nxt;
            r_mm <= w_mm_nxt;
            if (w_min_wrap) begin
              r_h  <= w_h_nxt;
              r_hh <= w_hh_nxt;
            end
          end
          r_blank <= 4'b0000;
          if (w_mode_evt) begin
            r_state <= S_SET_HH;
            r_blink <= '0;
          end else begin
            r_blink <= w_blink_inc;
          end
        end
        S_SET_HH: begin
          if (w_mode_evt) begin
            r_state <= S_SET_MM;
            r_blink <= '0;
            r_blank <= 4'b0000;
          end else if (w_inc_evt) begin
            r_h     <= w_h_nxt;
            r_hh    <= w_hh_nxt;
            r_blink <= '0;
            r_blank <= 4'b0000;
          end else begin
            r_blink <= w_blink_inc;
            r_blank <= w_blink_off ? 4'b1100 : 4'b0000;
          end
        end
        S_SET_MM: begin
          if (w_mode_evt) begin
            r_state  <= S_RUN;
            r_tb_clr <= 1'b1;
            r_blink  <= '0;
            r_blank  <= 4'b0000;
          end else if (w_inc_evt) begin
            r_m     <= w_m_nxt;
            r_mm    <= w_mm_nxt;
            r_blink <= '0;
            r_blank <= 4'b0000;
          end else begin
            r_blink <= w_blink_inc;
            r_blank <= w_blink_off ? 4'b0011 : 4'b0000;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_blink <= '0;
          r_blank <= 4'b0000;
        end
      endcase
    end
  end

  assign hh     = r_hh;
  assign h      = r_h;
  assign mm     = r_mm;
  assign m      = r_m;
  assign blank  = r_blank;
  assign mode   = r_state;
  assign tb_clr = r_tb_clr;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       tick_min = 1'b0;
  logic [3:0] hh, h, mm, m, blank;
  logic [1:0] mode;
  logic       tb_clr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] hh;
    logic [3:0] h;
    logic [3:0] mm;
    logic [3:0] m;
    logic [1:0] mode;
    logic [3:0] blank;
    logic       tb_clr;
    logic       chk_blank;
  } exp_t;

  typedef struct {
    int ticks;
    int hh, h, mm, m;
  } tvec_t;

  typedef struct {
    int n;
    int h, mm, m;
    logic [3:0] blank;
  } svec_t;

  exp_t  sb_q[$];
  tvec_t tv[9];
  svec_t hv[8];
  svec_t bv[9];

  clock_set_ctrl #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(32),
    .REPEAT_RATE (8),
    .BLINK_HALF  (16)
  ) dut (
    .clk     (clk),
    .res     (res),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .tick_min(tick_min),
    .hh      (hh),
    .h       (h),
    .mm      (mm),
    .m       (m),
    .blank   (blank),
    .mode    (mode),
    .tb_clr  (tb_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input int a, input int b, input int c, input int d,
                              input int md, input logic [3:0] bl, input logic clr,
                              input logic chk);
    exp_t e;
    e.hh        = 4'(a);
    e.h         = 4'(b);
    e.mm        = 4'(c);
    e.m         = 4'(d);
    e.mode      = 2'(md);
    e.blank     = bl;
    e.tb_clr    = clr;
    e.chk_blank = chk;
    return e;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input exp_t e);
    sb_q.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    logic ok;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, nothing to compare against", name);
      return;
    end
    e  = sb_q.pop_front();
    ok = (hh === e.hh) && (h === e.h) && (mm === e.mm) && (m === e.m) &&
         (mode === e.mode) && (tb_clr === e.tb_clr) &&
         (!e.chk_blank || (blank === e.blank));
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d%0d:%0d%0d mode=%0d blank=%b tb_clr=%b, expected %0d%0d:%0d%0d mode=%0d blank=%b(chk=%0b) tb_clr=%b",
               name, hh, h, mm, m, mode, blank, tb_clr,
               e.hh, e.h, e.mm, e.m, e.mode, e.blank, e.chk_blank, e.tb_clr);
    end
  endtask

  initial begin
    int tick_cnt;
    int k;

    tv[0] = '{1,    0, 0, 0, 1};
    tv[1] = '{60,   0, 1, 0, 0};
    tv[2] = '{599,  0, 9, 5, 9};
    tv[3] = '{600,  1, 0, 0, 0};
    tv[4] = '{1199, 1, 9, 5, 9};
    tv[5] = '{1200, 2, 0, 0, 0};
    tv[6] = '{1439, 2, 3, 5, 9};
    tv[7] = '{1440, 0, 0, 0, 0};
    tv[8] = '{2777, 2, 2, 1, 7};

    hv[0] = '{7,  0, 5, 9, 4'b0000};
    hv[1] = '{38, 0, 5, 9, 4'b0000};
    hv[2] = '{39, 0, 0, 0, 4'b0000};
    hv[3] = '{46, 0, 0, 0, 4'b0000};
    hv[4] = '{47, 0, 0, 1, 4'b0000};
    hv[5] = '{55, 0, 0, 2, 4'b0000};
    hv[6] = '{63, 0, 0, 3, 4'b0000};
    hv[7] = '{80, 0, 0, 3, 4'b0000};

    bv[0] = '{15, 0, 0, 3, 4'b0000};
    bv[1] = '{16, 0, 0, 3, 4'b1100};
    bv[2] = '{31, 0, 0, 3, 4'b1100};
    bv[3] = '{32, 0, 0, 3, 4'b0000};
    bv[4] = '{48, 0, 0, 3, 4'b1100};
    bv[5] = '{56, 0, 0, 3, 4'b1100};
    bv[6] = '{57, 1, 0, 3, 4'b0000};
    bv[7] = '{72, 1, 0, 3, 4'b0000};
    bv[8] = '{73, 1, 0, 3, 4'b1100};

    // Reset state
    wait_n(3);
    push_exp(mk(0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b1));
    check("reset_state");
    res = 1'b0;

    // Minute ticks in RUN, through every hour rollover
    tick_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      push_exp(mk(tv[i].hh, tv[i].h, tv[i].mm, tv[i].m, 0, 4'b0000, 1'b0, 1'b1));
      tick_min = 1'b1;
      wait_n(tv[i].ticks - tick_cnt);
      tick_min = 1'b0;
      tick_cnt = tv[i].ticks;
      check($sformatf("tick_%0d", tv[i].ticks));
    end
    wait_n(2);

    // Glitches shorter than the debounce window are rejected
    repeat (3) begin
      btn_mode = 1'b1;
      wait_n(2);
      btn_mode = 1'b0;
      wait_n(3);
    end
    wait_n(10);
    push_exp(mk(2, 2, 1, 7, 0, 4'b0000, 1'b0, 1'b1));
    check("glitch_no_mode");

    // Clean mode press: no change after 6 edges, SET_HH after 7
    btn_mode = 1'b1;
    push_exp(mk(2, 2, 1, 7, 0, 4'b0000, 1'b0, 1'b1));
    wait_n(6);
    check("mode_press_pre");
    push_exp(mk(2, 2, 1, 7, 1, 4'b0000, 1'b0, 1'b1));
    wait_n(1);
    check("mode_press_set_hh");
    btn_mode = 1'b0;
    wait_n(10);

    // SET_HH: 22 -> 23 -> 00, minutes untouched, ticks dropped
    btn_inc = 1'b1;
    push_exp(mk(2, 2, 1, 7, 1, 4'b0000, 1'b0, 1'b0));
    wait_n(6);
    check("inc_hh_pre");
    push_exp(mk(2, 3, 1, 7, 1, 4'b0000, 1'b0, 1'b1));
    wait_n(1);
    check("inc_hh_23");
    btn_inc = 1'b0;
    wait_n(10);
    btn_inc = 1'b1;
    push_exp(mk(0, 0, 1, 7, 1, 4'b0000, 1'b0, 1'b1));
    wait_n(7);
    check("inc_hh_wrap_00");
    btn_inc = 1'b0;
    wait_n(10);
    repeat (3) begin
      tick_min = 1'b1;
      wait_n(1);
      tick_min = 1'b0;
      wait_n(2);
    end
    push_exp(mk(0, 0, 1, 7, 1, 4'b0000, 1'b0, 1'b0));
    check("tick_ignored_set_hh");

    // SET_MM: step minutes 17 -> 58 with single presses
    btn_mode = 1'b1;
    push_exp(mk(0, 0, 1, 7, 2, 4'b0000, 1'b0, 1'b1));
    wait_n(7);
    check("mode_set_mm");
    btn_mode = 1'b0;
    wait_n(10);
    for (int i = 18; i <= 58; i++) begin
      btn_inc = 1'b1;
      push_exp(mk(0, 0, i / 10, i % 10, 2, 4'b0000, 1'b0, 1'b1));
      wait_n(7);
      check($sformatf("inc_mm_%0d", i));
      btn_inc = 1'b0;
      wait_n(10);
    end

    // Held inc: events at press, +32, +40, +48, +56 -> 58 becomes 03
    k = 0;
    btn_inc = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      if (k < 8 && hv[k].n == n)
        push_exp(mk(0, hv[k].h, hv[k].mm, hv[k].m, 2, 4'b0000, 1'b0, 1'b0));
      wait_n(1);
      if (k < 8 && hv[k].n == n) begin
        check($sformatf("repeat_n%0d", n));
        k++;
      end
      if (n == 60) btn_inc = 1'b0;
    end
    wait_n(10);

    // Mode press and inc event in the same cycle: mode wins, tb_clr pulses
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    push_exp(mk(0, 0, 0, 3, 2, 4'b0000, 1'b0, 1'b0));
    wait_n(6);
    check("exit_pre");
    push_exp(mk(0, 0, 0, 3, 0, 4'b0000, 1'b1, 1'b1));
    wait_n(1);
    check("exit_run_tb_clr");
    push_exp(mk(0, 0, 0, 3, 0, 4'b0000, 1'b0, 1'b1));
    wait_n(1);
    check("tb_clr_single_cycle");
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    wait_n(10);

    // Blink in SET_HH, inc mid-blank re-shows immediately
    btn_mode = 1'b1;
    push_exp(mk(0, 0, 0, 3, 1, 4'b0000, 1'b0, 1'b1));
    wait_n(7);
    check("blink_enter");
    btn_mode = 1'b0;
    k = 0;
    for (int n = 1; n <= 80; n++) begin
      if (k < 9 && bv[k].n == n)
        push_exp(mk(0, bv[k].h, bv[k].mm, bv[k].m, 1, bv[k].blank, 1'b0, 1'b1));
      wait_n(1);
      if (k < 9 && bv[k].n == n) begin
        check($sformatf("blink_k%0d", n));
        k++;
      end
      if (n == 50) btn_inc = 1'b1;
      if (n == 60) btn_inc = 1'b0;
    end
    wait_n(10);

    // Reset mid-SET_MM
    btn_mode = 1'b1;
    push_exp(mk(0, 1, 0, 3, 2, 4'b0000, 1'b0, 1'b1));
    wait_n(7);
    check("enter_set_mm_again");
    btn_mode = 1'b0;
    wait_n(10);
    res = 1'b1;
    push_exp(mk(0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b1));
    wait_n(1);
    check("reset_mid_set");
    res = 1'b0;
    push_exp(mk(0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b1));
    wait_n(1);
    check("post_reset_no_tb_clr");
    wait_n(4);

    // Button held through reset: press event DEB_CYCLES+2 after release
    btn_mode = 1'b1;
    res = 1'b1;
    wait_n(2);
    res = 1'b0;
    push_exp(mk(0, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b1));
    wait_n(6);
    check("held_reset_pre");
    push_exp(mk(0, 0, 0, 0, 1, 4'b0000, 1'b0, 1'b1));
    wait_n(1);
    check("held_reset_press");
    btn_mode = 1'b0;
    wait_n(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
